// File: rtl/vrf_wb_arbiter_pkg.sv
// Shared vector-lite types and writeback arbiter sizing.
package rvvLitePkg;

    localparam int unsigned SLOT_COUNT        = 3;
    localparam int unsigned LD_SLOT_COUNT     = 2;
    localparam int unsigned WB_ARB_NUM_SRC    = SLOT_COUNT + LD_SLOT_COUNT;
    localparam int unsigned WB_ARB_FIFO_DEPTH = 4;

    localparam int unsigned VRF_ADDR_W = 8;
    localparam int unsigned VRF_DATA_W = 64;
    localparam int unsigned VRF_BE_W   = 8;

    // One writeback beat; valid sits in the LSB so it can be stripped cheaply.
    typedef struct packed {
        logic [VRF_ADDR_W-1:0] addr;
        logic [VRF_DATA_W-1:0] data;
        logic [VRF_BE_W-1:0]   be;
        logic                  start_flag;
        logic                  end_flag;
        logic                  valid;
    } dstream_t;

    localparam int unsigned DSTREAM_W         = $bits(dstream_t);
    localparam int unsigned DSTREAM_PAYLOAD_W = DSTREAM_W - 1;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Beat contents without the valid bit.
    function automatic logic [DSTREAM_PAYLOAD_W-1:0] payload_of(input dstream_t b);
        return b[DSTREAM_W-1:1];
    endfunction

    // Rebuild a beat from stored payload plus a valid bit.
    function automatic dstream_t beat_of(input logic [DSTREAM_PAYLOAD_W-1:0] p, input logic v);
        return dstream_t'({p, v});
    endfunction

endpackage

// File: rtl/vrf_wb_arbiter_if.sv
// Source-side and VRF-side handshake bundle of the writeback arbiter.
interface vrf_wb_arbiter_if #(
    parameter int unsigned NUM_SRC = rvvLitePkg::WB_ARB_NUM_SRC
);
    import rvvLitePkg::*;

    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    dstream_t [NUM_SRC-1:0] in_stream;
    logic     [NUM_SRC-1:0] in_ready;
    dstream_t               out_stream;
    logic     [SRC_W-1:0]   out_src;
    logic                   out_ready;
    logic                   busy;

    // Environment side: drives sources and the VRF accept.
    modport master (
        output in_stream,
        input  in_ready,
        input  out_stream,
        input  out_src,
        output out_ready,
        input  busy
    );

    // Arbiter side.
    modport slave (
        input  in_stream,
        output in_ready,
        output out_stream,
        output out_src,
        input  out_ready,
        output busy
    );

endinterface

// File: rtl/vrf_wb_arbiter_src_fifo.sv
// Per-source beat FIFO: count-based full/empty, wrap-around pointers, valid not stored.
module wb_src_fifo
    import rvvLitePkg::*;
#(
    parameter int unsigned DEPTH = WB_ARB_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  dstream_t din_i,
    input  logic     pop_i,
    output dstream_t head_c_o,
    output logic     full_c_o,
    output logic     empty_c_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DSTREAM_PAYLOAD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_c_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_c_o = (cnt_q == '0);
    assign do_push   = push_i && din_i.valid && !full_c_o;
    assign do_pop    = pop_i && !empty_c_o;
    assign head_c_o  = beat_of(mem_q[rd_ptr_q], !empty_c_o);

    // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array, written on accepted push only.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= payload_of(din_i);
    end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Round-robin, packet-locking writeback arbiter feeding one VRF write port.
// Optional build macro VRF_WB_ARB_BYPASS_EN: a winning beat whose FIFO is empty
// skips the FIFO and loads the output register directly (latency 1 instead of 2).
module vrf_wb_arbiter
    import rvvLitePkg::*;
#(
    parameter int unsigned NUM_SRC    = WB_ARB_NUM_SRC,
    parameter int unsigned FIFO_DEPTH = WB_ARB_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    vrf_wb_arbiter_if.slave  bus
);

    localparam int unsigned     SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

    dstream_t [NUM_SRC-1:0] head_c;
    logic [NUM_SRC-1:0]     full_c, empty_c, push_c, pop_c, byp_c, cand_c;

    arb_state_e       state_q, state_d;
    logic [SRC_W-1:0] lock_src_q, lock_src_d;
    logic [SRC_W-1:0] rr_q, rr_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;
    dstream_t         out_q, out_d;

    logic             load_c, gnt_vld_c, byp_sel_c;
    logic [SRC_W-1:0] gnt_src_c;
    dstream_t         gnt_beat_c;

    // One FIFO per writeback source.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push_i    (push_c[i]),
            .din_i     (bus.in_stream[i]),
            .pop_i     (pop_c[i]),
            .head_c_o  (head_c[i]),
            .full_c_o  (full_c[i]),
            .empty_c_o (empty_c[i])
        );
    end

    // A source is a candidate when it has a beat to offer this cycle.
    always_comb begin
        cand_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand_c[i] = !empty_c[i];
`ifdef VRF_WB_ARB_BYPASS_EN
            if (empty_c[i] && bus.in_stream[i].valid) cand_c[i] = 1'b1;
`endif
        end
    end

    // Winner: locked source only, else first candidate at or after rr_q.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_vld_c = 1'b0;
        gnt_src_c = '0;
        if (state_q == ARB_LOCKED) begin
            gnt_vld_c = cand_c[lock_src_q];
            gnt_src_c = lock_src_q;
        end else begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                idx = 32'(rr_q) + k;
                if (idx >= NUM_SRC) idx = idx - NUM_SRC;
                if (!gnt_vld_c && cand_c[SRC_W'(idx)]) begin
                    gnt_vld_c = 1'b1;
                    gnt_src_c = SRC_W'(idx);
                end
            end
        end
    end

    // Winning beat comes from the FIFO head, or straight from the input when bypassing.
    always_comb begin
        gnt_beat_c = head_c[gnt_src_c];
        byp_sel_c  = 1'b0;
`ifdef VRF_WB_ARB_BYPASS_EN
        if (empty_c[gnt_src_c]) begin
            gnt_beat_c = bus.in_stream[gnt_src_c];
            byp_sel_c  = 1'b1;
        end
`endif
        gnt_beat_c.valid = 1'b1;
    end

    // Lock FSM next-state plus output-register load, pop and bypass selection.
    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        rr_d       = rr_q;
        out_d      = out_q;
        out_src_d  = out_src_q;
        pop_c      = '0;
        byp_c      = '0;
        load_c     = !out_q.valid || bus.out_ready;
        if (load_c) begin
            if (gnt_vld_c) begin
                out_d     = gnt_beat_c;
                out_src_d = gnt_src_c;
                if (byp_sel_c) byp_c[gnt_src_c] = 1'b1;
                else           pop_c[gnt_src_c] = 1'b1;
                if (gnt_beat_c.end_flag) begin
                    state_d = ARB_OPEN;
                    rr_d    = (gnt_src_c == LAST_SRC) ? '0 : gnt_src_c + SRC_W'(1);
                end else begin
                    state_d    = ARB_LOCKED;
                    lock_src_d = gnt_src_c;
                end
            end else begin
                out_d.valid = 1'b0;
            end
        end
    end

    // FIFO push: accepted beats not taken by the bypass path.
    always_comb begin
        push_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            push_c[i] = bus.in_stream[i].valid && !full_c[i] && !byp_c[i];
        end
    end

    // Arbiter state and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_OPEN;
            lock_src_q <= '0;
            rr_q       <= '0;
            out_q      <= '0;
            out_src_q  <= '0;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            rr_q       <= rr_d;
            out_q      <= out_d;
            out_src_q  <= out_src_d;
        end
    end

    assign bus.in_ready   = ~full_c;
    assign bus.out_stream = out_q;
    assign bus.out_src    = out_src_q;
    assign bus.busy       = ~(&empty_c) | out_q.valid;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Directed self-checking bench for vrf_wb_arbiter (default or bypass build).
`timescale 1ns/1ps
module tb_vrf_wb_arbiter;
    import rvvLitePkg::*;

    localparam int unsigned NSRC = 5;
`ifdef VRF_WB_ARB_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    typedef struct {
        logic [2:0] src;
        dstream_t   beat;
        int         cyc;
    } obs_t;
    obs_t obs_q[$];

    vrf_wb_arbiter_if #(.NUM_SRC(NSRC)) bus ();

    vrf_wb_arbiter #(.NUM_SRC(NSRC), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every beat the VRF port accepts.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_stream.valid === 1'b1 && bus.out_ready === 1'b1)
            obs_q.push_back('{src: bus.out_src, beat: bus.out_stream, cyc: cyc});
    end

    function automatic dstream_t mk(input logic [7:0] a, input logic [63:0] d,
                                    input logic [7:0] be, input logic s, input logic e);
        dstream_t b;
        b.addr = a; b.data = d; b.be = be;
        b.start_flag = s; b.end_flag = e; b.valid = 1'b1;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NSRC; i++) bus.in_stream[i] = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain: busy=%b after %0d cycles, required 0", tag, bus.busy, n);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.out_stream !== '0) begin
            bad++; $display("FAIL reset_out: got %h, required 0", bus.out_stream);
        end
        total++;
        if (bus.out_src !== 3'd0) begin
            bad++; $display("FAIL reset_src: got %0d, required 0", bus.out_src);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b, required 0", bus.busy);
        end
        rst_n = 1'b1;
        step();
        total++;
        if (bus.in_ready !== 5'b11111) begin
            bad++; $display("FAIL reset_ready: got %b, required 11111", bus.in_ready);
        end
    endtask

    task automatic test_two_single();
        obs_q.delete();
        bus.in_stream[0] = mk(8'h01, 64'h1111, 8'hFF, 1'b1, 1'b1);
        bus.in_stream[2] = mk(8'h02, 64'h2222, 8'hFF, 1'b1, 1'b1);
        step();
        idle_inputs();
        wait_idle("two_single");
        total++;
        if (obs_q.size() != 2) begin
            bad++; $display("FAIL two_single_count: got %0d, required 2", obs_q.size());
        end else begin
            total++;
            if (obs_q[0].src !== 3'd0 || obs_q[0].beat.addr !== 8'h01) begin
                bad++; $display("FAIL two_single_first: src=%0d addr=%h, required src=0 addr=01",
                                obs_q[0].src, obs_q[0].beat.addr);
            end
            total++;
            if (obs_q[1].src !== 3'd2 || obs_q[1].beat.addr !== 8'h02) begin
                bad++; $display("FAIL two_single_second: src=%0d addr=%h, required src=2 addr=02",
                                obs_q[1].src, obs_q[1].beat.addr);
            end
            total++;
            if (obs_q[1].cyc != obs_q[0].cyc + 1) begin
                bad++; $display("FAIL two_single_consec: cycles %0d,%0d, required consecutive",
                                obs_q[0].cyc, obs_q[1].cyc);
            end
        end
        // rr_ptr now 3: src3 must beat src1.
        obs_q.delete();
        bus.in_stream[1] = mk(8'h03, 64'h3333, 8'hFF, 1'b1, 1'b1);
        bus.in_stream[3] = mk(8'h04, 64'h4444, 8'hFF, 1'b1, 1'b1);
        step();
        idle_inputs();
        wait_idle("rr_ptr");
        total++;
        if (obs_q.size() != 2 || obs_q[0].src !== 3'd3 || obs_q[1].src !== 3'd1) begin
            bad++; $display("FAIL rr_ptr_order: count=%0d first=%0d second=%0d, required 2,3,1",
                            obs_q.size(), obs_q[0].src, obs_q[1].src);
        end
    endtask

    task automatic test_locked_packet();
        logic [2:0] exp_src  [8] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3};
        logic [7:0] exp_addr [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h31, 8'h32, 8'h33};
        logic       exp_end  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        obs_q.delete();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) bus.in_stream[1] = mk(8'h10 + 8'(k), 64'(k), 8'hFF, k == 0, k == 3);
            else       bus.in_stream[1] = '0;
            if (k > 0) bus.in_stream[3] = mk(8'h30 + 8'(k - 1), 64'(k + 100), 8'hFF, 1'b1, 1'b1);
            else       bus.in_stream[3] = '0;
            step();
        end
        idle_inputs();
        wait_idle("locked");
        total++;
        if (obs_q.size() != 8) begin
            bad++; $display("FAIL locked_count: got %0d, required 8", obs_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (obs_q.size() > i) begin
                total++;
                if (obs_q[i].src !== exp_src[i] || obs_q[i].beat.addr !== exp_addr[i] ||
                    obs_q[i].beat.end_flag !== exp_end[i]) begin
                    bad++; $display("FAIL locked_beat[%0d]: src=%0d addr=%h end=%b, required src=%0d addr=%h end=%b",
                                    i, obs_q[i].src, obs_q[i].beat.addr, obs_q[i].beat.end_flag,
                                    exp_src[i], exp_addr[i], exp_end[i]);
                end
            end
        end
        if (obs_q.size() >= 4) begin
            total++;
            if (obs_q[3].cyc != obs_q[0].cyc + 3) begin
                bad++; $display("FAIL locked_contig: span=%0d, required 3", obs_q[3].cyc - obs_q[0].cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        int   k;
        logic rdy;
        k = 0;
        obs_q.delete();
        bus.out_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            bus.in_stream[0] = mk(8'h40 + 8'(k), 64'hA0 + 64'(k), 8'hFF, 1'b1, 1'b1);
            @(negedge clk);
            rdy = bus.in_ready[0];
            total++;
            if (rdy !== 1'(j < 5)) begin
                bad++; $display("FAIL bp_ready[%0d]: got %b, required %b", j, rdy, 1'(j < 5));
            end
            if (j >= 2) begin
                total++;
                if (bus.out_stream.valid !== 1'b1 || bus.out_stream.addr !== 8'h40) begin
                    bad++; $display("FAIL bp_hold[%0d]: valid=%b addr=%h, required valid=1 addr=40",
                                    j, bus.out_stream.valid, bus.out_stream.addr);
                end
            end
            @(posedge clk);
            #1;
            if (rdy) k++;
        end
        idle_inputs();
        total++;
        if (k != 5) begin
            bad++; $display("FAIL bp_accepted: got %0d, required 5", k);
        end
        bus.out_ready = 1'b1;
        wait_idle("bp");
        total++;
        if (obs_q.size() != 5) begin
            bad++; $display("FAIL bp_count: got %0d, required 5", obs_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (obs_q.size() > i) begin
                total++;
                if (obs_q[i].src !== 3'd0 || obs_q[i].beat.addr !== 8'h40 + 8'(i)) begin
                    bad++; $display("FAIL bp_beat[%0d]: src=%0d addr=%h, required src=0 addr=%h",
                                    i, obs_q[i].src, obs_q[i].beat.addr, 8'h40 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        obs_q.delete();
        bus.in_stream[2] = mk(8'h20, 64'h20, 8'hFF, 1'b1, 1'b0);
        step();
        bus.in_stream[2] = mk(8'h21, 64'h21, 8'hFF, 1'b0, 1'b0);
        step();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_stream.valid !== 1'b0) begin
            bad++; $display("FAIL midrst_valid: got %b, required 0", bus.out_stream.valid);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_busy: got %b, required 0", bus.busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        obs_q.delete();
        bus.in_stream[4] = mk(8'h28, 64'h28, 8'hFF, 1'b1, 1'b0);
        step();
        bus.in_stream[4] = mk(8'h29, 64'h29, 8'hFF, 1'b0, 1'b1);
        step();
        idle_inputs();
        wait_idle("midrst");
        total++;
        if (obs_q.size() != 2) begin
            bad++; $display("FAIL midrst_count: got %0d, required 2", obs_q.size());
        end else begin
            total++;
            if (obs_q[0].src !== 3'd4 || obs_q[0].beat.addr !== 8'h28 ||
                obs_q[1].src !== 3'd4 || obs_q[1].beat.addr !== 8'h29) begin
                bad++; $display("FAIL midrst_beats: %0d/%h %0d/%h, required 4/28 4/29",
                                obs_q[0].src, obs_q[0].beat.addr, obs_q[1].src, obs_q[1].beat.addr);
            end
        end
    endtask

    task automatic test_latency();
        int c0;
        obs_q.delete();
        bus.in_stream[4] = mk(8'h2A, 64'h5, 8'h01, 1'b1, 1'b1);
        c0 = cyc;
        step();
        idle_inputs();
        wait_idle("latency");
        total++;
        if (obs_q.size() != 1 || obs_q[0].src !== 3'd4) begin
            bad++; $display("FAIL latency_beat: count=%0d src=%0d, required 1 beat from src 4",
                            obs_q.size(), obs_q[0].src);
        end
        total++;
        if (obs_q[0].cyc != c0 + EXP_LAT) begin
            bad++; $display("FAIL latency_cycles: got %0d, required %0d", obs_q[0].cyc - c0, EXP_LAT);
        end
    endtask

    task automatic test_passthrough();
        for (int s = 0; s < NSRC; s++) begin
            obs_q.delete();
            bus.in_stream[s] = mk(8'h50 + 8'(s), 64'hDEAD_BEEF_0123_4567, 8'h0F, 1'b1, 1'b1);
            step();
            idle_inputs();
            wait_idle("pass");
            total++;
            if (obs_q.size() != 1) begin
                bad++; $display("FAIL pass_count[%0d]: got %0d, required 1", s, obs_q.size());
            end else begin
                total++;
                if (obs_q[0].src !== 3'(s)) begin
                    bad++; $display("FAIL pass_src[%0d]: got %0d, required %0d", s, obs_q[0].src, s);
                end
                total++;
                if (obs_q[0].beat.addr !== 8'h50 + 8'(s)) begin
                    bad++; $display("FAIL pass_addr[%0d]: got %h, required %h", s, obs_q[0].beat.addr, 8'h50 + 8'(s));
                end
                total++;
                if (obs_q[0].beat.data !== 64'hDEAD_BEEF_0123_4567) begin
                    bad++; $display("FAIL pass_data[%0d]: got %h, required deadbeef01234567", s, obs_q[0].beat.data);
                end
                total++;
                if (obs_q[0].beat.be !== 8'h0F) begin
                    bad++; $display("FAIL pass_be[%0d]: got %h, required 0f", s, obs_q[0].beat.be);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_single();
        test_locked_packet();
        test_backpressure();
        test_mid_reset();
        test_latency();
        test_passthrough();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vrf_wb_arbiter.md
VRF_WB_ARBITER -- requirements
Module: vrf_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 5 (SLOT_COUNT+LD_SLOT_COUNT), number of writeback sources; legal range 2..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per source FIFO; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_stream, input, NUM_SRC x dstream_t, per-source beat (addr, data, valid, start_flag, end_flag, be).
REQ-006 SHALL have port in_ready, output, NUM_SRC, per-source accept; a beat transfers when in_stream[i].valid and in_ready[i] are both high.
REQ-007 SHALL have port out_stream, output, dstream_t, registered beat to the VRF write port.
REQ-008 SHALL have port out_src, output, clog2(NUM_SRC), index of the source of the current out_stream beat.
REQ-009 SHALL have port out_ready, input, 1, VRF port accept; a beat transfers when out_stream.valid and out_ready are both high.
REQ-010 SHALL have port busy, output, 1, high while any FIFO is non-empty or out_stream.valid is high.

Function
REQ-011 SHALL give each source a FIFO of FIFO_DEPTH dstream_t entries (valid bit not stored).
REQ-012 SHALL drive in_ready[i] = FIFO i not full, independent of in_stream[i].valid; a full FIFO SHALL deassert ready even if it is popped in the same cycle.
REQ-013 SHALL load the output register whenever out_stream.valid is 0 or out_ready is 1 ("load slot"); otherwise out_stream and out_src SHALL hold stable.
REQ-014 SHALL, in a load slot with no lock, grant the first non-empty FIFO at or after rr_ptr (round-robin), pop its head into the output register, and set out_src.
REQ-015 SHALL set lock to the granted source when the granted beat has end_flag=0; while locked, only that source is eligible, and empty cycles produce out_stream.valid=0.
REQ-016 SHALL clear lock and set rr_ptr to (granted source + 1) mod NUM_SRC when a granted beat has end_flag=1; with no lock, rr_ptr SHALL still advance after every single-beat grant.
REQ-017 SHALL clear out_stream.valid in a load slot when no source is eligible.
REQ-018 SHALL give a FIFO-path latency of 2 cycles: a beat accepted in cycle N appears on out_stream in cycle N+2 at the earliest.
REQ-019 SHALL preserve per-source beat order, and SHALL never interleave beats of a locked packet with beats of another source.
REQ-020 SHALL pass addr, data, be, start_flag and end_flag through unmodified.

Reset
REQ-021 SHALL on rst_n low immediately empty all FIFOs, clear lock, set rr_ptr=0, out_stream to all-zero (valid=0), out_src=0 and busy=0; in_ready SHALL be all ones once rst_n is high.
REQ-022 SHALL discard any partially transferred packet on reset; no beat of it SHALL appear after reset.

Configuration
REQ-023 SHALL support macro VRF_WB_ARB_BYPASS_EN; when it is defined, an input beat whose FIFO is empty and whose source would win arbitration in a load slot SHALL go straight into the output register (latency 1) without entering the FIFO, and lock/rr_ptr SHALL update exactly as for a FIFO grant.
REQ-024 SHALL, when VRF_WB_ARB_BYPASS_EN is undefined, route every beat through its FIFO (latency 2); ordering and arbitration results SHALL be identical in both builds.

Structure
REQ-025 SHALL place localparams WB_ARB_NUM_SRC and WB_ARB_FIFO_DEPTH in rvvLitePkg and reuse the dstream_t defined there; no new typedef in the module.
REQ-026 SHALL implement the per-source FIFO as sub-module wb_src_fifo (parametrised depth, count-based full/empty, wrap-around pointers), instantiated NUM_SRC times.

Verification
REQ-027 SHALL cover: sources 0 and 2 each push one single-beat packet (start=end=1) in the same cycle -> outputs src0 then src2 on consecutive cycles; rr_ptr=3 afterwards.
REQ-028 SHALL cover: src1 sends a 4-beat packet (addr 0x10..0x13) while src3 streams single beats -> all four src1 beats appear contiguously, src3 only after the end beat.
REQ-029 SHALL cover: out_ready held low for 6 cycles with src0 pushing continuously -> in_ready[0] drops after 4 accepted beats (plus 1 in the output register); no beat lost or duplicated; out_stream stays stable.
REQ-030 SHALL cover: rst_n asserted mid-packet (after beat 2 of 4) -> out_stream.valid=0 and busy=0 immediately; the next packet is output correctly with no stale beats.
REQ-031 SHALL cover: an idle arbiter receiving a beat on src4 in cycle N -> out_stream.valid in cycle N+1 with VRF_WB_ARB_BYPASS_EN, N+2 without it.
REQ-032 SHALL cover: data 0xDEAD_BEEF_0123_4567 with be=0x0F through each source -> identical addr, data and be on output, with the correct out_src.
